// File: rtl/demux1_4_reg_if.sv
// Bundles the input and output handshakes of the 1-to-4 demultiplexer.
// The master side supplies words and destination readies; the slave side
// is the demultiplexer itself.
interface demux1_4_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] DemuxIn;
    logic [1:0]            Sel;
    logic                  InValid;
    logic                  InReady;
    logic [DATA_WIDTH-1:0] DemuxOut0;
    logic [DATA_WIDTH-1:0] DemuxOut1;
    logic [DATA_WIDTH-1:0] DemuxOut2;
    logic [DATA_WIDTH-1:0] DemuxOut3;
    logic [3:0]            OutValid;
    logic [3:0]            OutReady;
    logic [CNT_WIDTH-1:0]  XferCount;

    modport master (
        output DemuxIn, Sel, InValid, OutReady,
        input  InReady, DemuxOut0, DemuxOut1, DemuxOut2, DemuxOut3,
               OutValid, XferCount
    );

    modport slave (
        input  DemuxIn, Sel, InValid, OutReady,
        output InReady, DemuxOut0, DemuxOut1, DemuxOut2, DemuxOut3,
               OutValid, XferCount
    );
endinterface

// File: rtl/demux1_4_reg.sv
// Registered 1-to-4 demultiplexer. A word accepted on the input handshake
// is held in a single-entry register and presented only on the selected
// destination port until that destination accepts it. A word can be
// accepted on the same edge the held one drains, so a ready destination
// sees one word per cycle. XferCount counts completed output transfers.
module demux1_4_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic          Clk,
    input  logic          Rst,
    demux1_4_reg_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            sel_q, sel_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  out_xfer_s;
    logic                  in_ready_s;
    logic                  in_xfer_s;
    logic [3:0]            out_valid_s;
    logic [DATA_WIDTH-1:0] dout_s [4];

    // Handshake decode: only the ready of the held word's destination matters.
    always_comb begin
        out_xfer_s = 1'b0;
        if (state_q == HOLD) begin
            out_xfer_s = bus.OutReady[sel_q];
        end else begin
            out_xfer_s = 1'b0;
        end
        in_ready_s = (state_q == IDLE) || out_xfer_s;
        in_xfer_s  = bus.InValid && in_ready_s;
    end

    // Next-state logic: load on input transfer, drain on output-only transfer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_xfer_s) begin
                    state_d = HOLD;
                    data_d  = bus.DemuxIn;
                    sel_d   = bus.Sel;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (in_xfer_s) begin
                    state_d = HOLD;
                    data_d  = bus.DemuxIn;
                    sel_d   = bus.Sel;
                end else if (out_xfer_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (out_xfer_s) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, held word and transfer counter; reset discards any pending word.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output steering from registered state only; unselected ports read zero.
    always_comb begin
        out_valid_s = 4'b0000;
        if (state_q == HOLD) begin
            out_valid_s = 4'b0001 << sel_q;
        end else begin
            out_valid_s = 4'b0000;
        end
        for (int i = 0; i < 4; i++) begin
            if (out_valid_s[i]) begin
                dout_s[i] = data_q;
            end else begin
                dout_s[i] = '0;
            end
        end
    end

    assign bus.InReady   = in_ready_s;
    assign bus.OutValid  = out_valid_s;
    assign bus.DemuxOut0 = dout_s[0];
    assign bus.DemuxOut1 = dout_s[1];
    assign bus.DemuxOut2 = dout_s[2];
    assign bus.DemuxOut3 = dout_s[3];
    assign bus.XferCount = cnt_q;
endmodule
